// File: rtl/tape_pkg.sv
// Shared CSW recording constants, FSM states and the pulse-length encoding helper
// used by the tape recorder and its byte FIFO.
package tape_pkg;

    localparam logic [7:0] CSW_ESCAPE    = 8'h00;
    localparam int         CSW_EXT_BYTES = 4;
    localparam int         CSW_RATE      = 44100;
    localparam int         FIFO_DEPTH    = 8;

    typedef enum logic [1:0] {
        IDLE,
        REC,
        FLUSH,
        DONE
    } state_t;

    // Short pulses fit in one byte; longer ones need the escape plus a 32-bit length.
    function automatic logic [2:0] emit_len(input logic [31:0] count);
        return (count < 32'd256) ? 3'd1 : 3'(CSW_EXT_BYTES + 1);
    endfunction

endpackage

// File: rtl/tape_rec_fifo.sv
// 8x8 byte FIFO that accepts up to five bytes per cycle (byte 0 in the low lane)
// and hands out one byte per pop; reports how many entries are still free.
module tape_rec_fifo
    import tape_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  push_n,
    input  logic [39:0] push_data,
    input  logic        pop,
    output logic [7:0]  rd_data,
    output logic        empty,
    output logic [3:0]  free
);

    logic [7:0] mem [FIFO_DEPTH];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       pop_ok;

    assign empty   = (count == 4'd0);
    assign free    = 4'(FIFO_DEPTH) - count;
    assign rd_data = mem[rd_ptr];
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (3'(i) < push_n)
                mem[wr_ptr + 3'(i)] <= push_data[8*i +: 8];
        end
    end

    // A push and a pop in the same cycle move the count by their net effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            wr_ptr <= wr_ptr + push_n;
            if (pop_ok)
                rd_ptr <= rd_ptr + 3'd1;
            count <= count + {1'b0, push_n} - {3'b000, pop_ok};
        end
    end

endmodule

// File: rtl/tape_rec.sv
// CSW tape recorder: measures MIC level pulse lengths in sample ticks, encodes them
// as CSW bytes into a small FIFO and writes them out to SDRAM one byte per request.
module tape_rec
    import tape_pkg::*;
#(
    parameter int          CLK_DIV   = 635,
    parameter logic [24:0] BASE_ADDR = 25'h400000,
    parameter logic [24:0] MAX_SIZE  = 25'h100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mic_in,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [24:0] a,
    output logic [7:0]  d,
    output logic [24:0] size,
    output logic        recording,
    output logic        done,
    output logic        overflow,
    output logic        full
);

    state_t      state_q, state_d;
    logic        mic_s1, mic_s2;
    logic        enable_q;
    logic [31:0] div_q;
    logic [31:0] cnt_q;
    logic        prev_q;

    logic        rise, fall, in_rec, enter_rec, tick, edge_det;
    logic [31:0] cnt_inc, cnt_eff;
    logic        emit, fits, drop;
    logic [2:0]  emit_n, push_n;
    logic [39:0] emit_bytes;
    logic        pop, fifo_empty;
    logic [7:0]  fifo_data;
    logic [3:0]  fifo_free;

    assign rise      = enable && !enable_q;
    assign fall      = !enable && enable_q;
    assign in_rec    = (state_q == REC);
    assign enter_rec = (state_d == REC) && !in_rec;
    assign tick      = in_rec && (div_q == 32'(CLK_DIV - 1));
    assign edge_det  = tick && (mic_s2 != prev_q);

    // The tick that detects an edge, or coincides with the stop, belongs to the pulse.
    assign cnt_inc    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign cnt_eff    = tick ? cnt_inc : cnt_q;
    assign emit       = edge_det || (in_rec && fall && (cnt_eff != 32'd0));
    assign emit_n     = emit_len(cnt_eff);
    assign emit_bytes = (cnt_eff < 32'd256) ? {32'd0, cnt_eff[7:0]} : {cnt_eff, CSW_ESCAPE};
    assign fits       = ({1'b0, emit_n} <= fifo_free);
    assign push_n     = (emit && fits) ? emit_n : 3'd0;
    assign drop       = emit && !fits;

    assign pop       = !fifo_empty && !wr_req;
    assign recording = (state_q == REC) || (state_q == FLUSH);
    assign done      = (state_q == DONE);

    tape_rec_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_n    (push_n),
        .push_data (emit_bytes),
        .pop       (pop),
        .rd_data   (fifo_data),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    // enable_q resets high so an enable already asserted at reset is not seen as a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            enable_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = REC;
            REC:     if (fall) state_d = FLUSH;
            FLUSH:   if (fifo_empty && !wr_req) state_d = DONE;
            DONE:    if (rise) state_d = REC;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mic_s1   <= 1'b0;
            mic_s2   <= 1'b0;
            div_q    <= 32'd0;
            cnt_q    <= 32'd0;
            prev_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            mic_s1 <= mic_in;
            mic_s2 <= mic_s1;
            if (enter_rec) begin
                div_q    <= 32'd0;
                cnt_q    <= 32'd0;
                prev_q   <= mic_s2;
                overflow <= 1'b0;
            end else if (in_rec) begin
                div_q <= tick ? 32'd0 : div_q + 32'd1;
                if (tick)
                    prev_q <= mic_s2;
                cnt_q <= emit ? 32'd0 : cnt_eff;
                if (drop)
                    overflow <= 1'b1;
            end else begin
                div_q <= 32'd0;
            end
        end
    end

    // Once the buffer is full, popped bytes are discarded instead of requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_req <= 1'b0;
            a      <= 25'd0;
            d      <= 8'd0;
            size   <= 25'd0;
            full   <= 1'b0;
        end else if (enter_rec) begin
            size <= 25'd0;
            full <= 1'b0;
        end else begin
            if (wr_req && wr_ack) begin
                wr_req <= 1'b0;
                size   <= size + 25'd1;
                if (size + 25'd1 == MAX_SIZE)
                    full <= 1'b1;
            end
            if (pop && !full) begin
                d      <= fifo_data;
                a      <= BASE_ADDR + size;
                wr_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tape_rec.sv
// Directed bench for tape_rec: a default-size and a 2-byte-capacity instance share the
// stimulus, and responders acknowledge and log every write request.
module tb_tape_rec;
    import tape_pkg::*;

    localparam logic [24:0] BASE = 25'h400000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mic_in = 1'b0;
    logic        wr_ack = 1'b0;
    logic        wr_ack_s = 1'b0;

    logic        wr_req, recording, done, overflow, full;
    logic [24:0] a, size;
    logic [7:0]  d;
    logic        wr_req_s, recording_s, done_s, overflow_s, full_s;
    logic [24:0] a_s, size_s;
    logic [7:0]  d_s;

    int          checks = 0;
    int          failures = 0;
    int          t = 0;
    bit          ack_en = 1'b1;
    logic [32:0] wq[$];
    logic [32:0] wq_s[$];
    logic [7:0]  exp_b[5];

    always #5 clk = ~clk;

    tape_rec #(.CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mic_in(mic_in),
        .wr_req(wr_req), .wr_ack(wr_ack), .a(a), .d(d), .size(size),
        .recording(recording), .done(done), .overflow(overflow), .full(full)
    );

    tape_rec #(.CLK_DIV(4), .MAX_SIZE(25'd2)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .mic_in(mic_in),
        .wr_req(wr_req_s), .wr_ack(wr_ack_s), .a(a_s), .d(d_s), .size(size_s),
        .recording(recording_s), .done(done_s), .overflow(overflow_s), .full(full_s)
    );

    // Acknowledge one cycle after wr_req is seen, logging the address/data pair.
    initial begin : resp_main
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en) begin
                if (wr_ack) begin
                    wr_ack = 1'b0;
                end else if (wr_req) begin
                    if (seen) begin
                        wq.push_back({a, d});
                        wr_ack = 1'b1;
                        seen = 1'b0;
                    end else begin
                        seen = 1'b1;
                    end
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin : resp_small
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_ack_s) begin
                wr_ack_s = 1'b0;
            end else if (wr_req_s) begin
                if (seen) begin
                    wq_s.push_back({a_s, d_s});
                    wr_ack_s = 1'b1;
                    seen = 1'b0;
                end else begin
                    seen = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic en_level);
        enable = en_level;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        wq.delete();
        wq_s.delete();
        t = 0;
    endtask

    task automatic start_take();
        enable = 1'b1;
        @(negedge clk);
        t = 0;
    endtask

    task automatic goto_n(input int n);
        while (t < n) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(done), 64'd1);
    endtask

    task automatic expect_writes(input string tag, input int n, input logic [7:0] bytes_in [5]);
        logic [32:0] got;
        checkOutput({tag, "_count"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < wq.size()) ? wq[i] : '1;
            checkOutput($sformatf("%s_w%0d", tag, i), 64'(got), 64'({BASE + 25'(i), bytes_in[i]}));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_req", 64'(wr_req), 64'd0);
        checkOutput("rst_recording", 64'(recording), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_full", 64'(full), 64'd0);
        checkOutput("rst_size", 64'(size), 64'd0);
        checkOutput("rst_addr_data", 64'({a, d}), 64'd0);
        checkOutput("rst_state", 64'(dut.state_q), 64'(IDLE));

        // Enable held high through reset must not start a take.
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        checkOutput("no_start_high", 64'(recording), 64'd0);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Three 10-tick pulses.
        do_reset(1'b0);
        start_take();
        checkOutput("rec_entry", 64'(recording), 64'd1);
        goto_n(35);  mic_in = ~mic_in;
        goto_n(75);  mic_in = ~mic_in;
        goto_n(115); mic_in = ~mic_in;
        goto_n(120); enable = 1'b0;
        wait_done("short_done");
        checkOutput("short_size", 64'(size), 64'd3);
        checkOutput("short_recording", 64'(recording), 64'd0);
        exp_b = '{8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h00};
        expect_writes("short", 3, exp_b);
        checkOutput("small_writes", 64'(wq_s.size()), 64'd2);
        checkOutput("small_full", 64'(full_s), 64'd1);
        checkOutput("small_size", 64'(size_s), 64'd2);
        checkOutput("small_done", 64'(done_s), 64'd1);
        checkOutput("small_overflow", 64'(overflow_s), 64'd0);

        // One 300-tick pulse needs the extended encoding.
        do_reset(1'b0);
        start_take();
        goto_n(1195); mic_in = ~mic_in;
        goto_n(1200); enable = 1'b0;
        wait_done("long_done");
        checkOutput("long_size", 64'(size), 64'd5);
        exp_b = '{8'h00, 8'h2C, 8'h01, 8'h00, 8'h00};
        expect_writes("long", 5, exp_b);

        // Stalled writer: the second and third long pulses cannot fit.
        do_reset(1'b0);
        ack_en = 1'b0;
        start_take();
        goto_n(1195); mic_in = ~mic_in;
        goto_n(2395); mic_in = ~mic_in;
        goto_n(3595); mic_in = ~mic_in;
        goto_n(3600);
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        checkOutput("ovf_req_held", 64'(wr_req), 64'd1);
        checkOutput("ovf_size_stall", 64'(size), 64'd0);
        checkOutput("ovf_no_writes", 64'(wq.size()), 64'd0);
        enable = 1'b0;
        ack_en = 1'b1;
        wait_done("ovf_done");
        checkOutput("ovf_size", 64'(size), 64'd5);
        checkOutput("ovf_sticky", 64'(overflow), 64'd1);
        expect_writes("ovf", 5, exp_b);

        // Reset in the middle of a request.
        do_reset(1'b0);
        ack_en = 1'b0;
        start_take();
        goto_n(35); mic_in = ~mic_in;
        goto_n(43);
        checkOutput("mid_req_high", 64'(wr_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_req_drop", 64'(wr_req), 64'd0);
        checkOutput("mid_size", 64'(size), 64'd0);
        checkOutput("mid_recording", 64'(recording), 64'd0);
        checkOutput("mid_state", 64'(dut.state_q), 64'(IDLE));
        reset  = 1'b0;
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("late_ack_req", 64'(wr_req), 64'd0);
        checkOutput("late_ack_size", 64'(size), 64'd0);

        // Stop with a partial 7-tick pulse and no edge pending.
        do_reset(1'b0);
        ack_en = 1'b1;
        start_take();
        goto_n(29); enable = 1'b0;
        wait_done("final_done");
        checkOutput("final_recording", 64'(recording), 64'd0);
        checkOutput("final_size", 64'(size), 64'd1);
        exp_b = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_writes("final", 1, exp_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
